// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky o_misalign flag and word-aligns redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic [12:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc4_d,
  output logic [31:0] o_instr_d,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        o_misalign,
`endif
  output logic        o_valid_d
);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] target_eff;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  assign target_eff = {i_target[31:2], 2'b00};

  always_comb begin
    misalign_d = misalign_q;
    if (i_redirect && (i_target[1:0] != 2'b00)) misalign_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) misalign_q <= 1'b0;
    else         misalign_q <= misalign_d;
  end

  assign o_misalign = misalign_q;
`else
  assign target_eff = i_target;
`endif

  // PC: redirect wins over stall so a taken branch is never lost behind a stall
  always_comb begin
    pc_d = pc_q;
    if (i_redirect)    pc_d = target_eff;
    else if (!i_stall) pc_d = pc_plus4;
  end

  // IF/ID: flush beats stall so a bubble is inserted even while the stage is held
  always_comb begin
    pc_id_d  = pc_id_q;
    pc4_id_d = pc4_id_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    if (i_flush) begin
      pc_id_d  = 32'h0;
      pc4_id_d = 32'h0;
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
    end else if (!i_stall) begin
      pc_id_d  = pc_q;
      pc4_id_d = pc_plus4;
      instr_d  = i_imem_rdata;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q     <= RESET_PC;
      pc_id_q  <= 32'h0;
      pc4_id_q <= 32'h0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_id_q  <= pc_id_d;
      pc4_id_q <= pc4_id_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_imem_addr = pc_q[12:0];
  assign o_pc_d      = pc_id_q;
  assign o_pc4_d     = pc4_id_q;
  assign o_instr_d   = instr_q;
  assign o_valid_d   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns word = byte address.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_reset, i_stall, i_flush, i_redirect;
  logic [31:0] i_target;
  logic [12:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc, o_pc_d, o_pc4_d, o_instr_d;
  logic        o_valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        o_misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  assign i_imem_rdata = {19'h0, o_imem_addr};

  fetch_unit dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_redirect   (i_redirect),
    .i_target     (i_target),
    .o_imem_addr  (o_imem_addr),
    .i_imem_rdata (i_imem_rdata),
    .o_pc         (o_pc),
    .o_pc_d       (o_pc_d),
    .o_pc4_d      (o_pc4_d),
    .o_instr_d    (o_instr_d),
`ifdef FETCH_MISALIGN_CHK_EN
    .o_misalign   (o_misalign),
`endif
    .o_valid_d    (o_valid_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input logic rst, input logic stl, input logic fl,
                        input logic rd, input logic [31:0] tgt);
    i_reset = rst; i_stall = stl; i_flush = fl; i_redirect = rd; i_target = tgt;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc_e,
                            input logic [31:0] pc4_e, input logic [31:0] ins_e,
                            input logic vld_e);
    check({tag, "_pc_d"},  o_pc_d,    pc_e);
    check({tag, "_pc4_d"}, o_pc4_d,   pc4_e);
    check({tag, "_instr"}, o_instr_d, ins_e);
    check({tag, "_valid"}, {31'h0, o_valid_d}, {31'h0, vld_e});
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    check("rst_pc", o_pc, 32'h0);
    check("rst_addr", {19'h0, o_imem_addr}, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 32'h13, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("rst_misalign", {31'h0, o_misalign}, 32'h0);
`endif

    // free run from reset, instruction lags PC by one cycle
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("run1_pc", o_pc, 32'h4);
    check_ifid("run1", 32'h0, 32'h4, 32'h0, 1'b1);
    step();
    check("run2_pc", o_pc, 32'h8);
    check_ifid("run2", 32'h4, 32'h8, 32'h4, 1'b1);
    step();
    check("run3_pc", o_pc, 32'hC);
    check_ifid("run3", 32'h8, 32'hC, 32'h8, 1'b1);
    step();
    check("run4_pc", o_pc, 32'h10);
    check_ifid("run4", 32'hC, 32'h10, 32'hC, 1'b1);

    // three-cycle stall at 0x10
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc", o_pc, 32'h10);
      check_ifid("stall", 32'hC, 32'h10, 32'hC, 1'b1);
    end
    i_stall = 1'b0;
    step();
    check("unstall_pc", o_pc, 32'h14);
    check_ifid("unstall", 32'h10, 32'h14, 32'h10, 1'b1);
    step(); step(); step();
    check("pre_br_pc", o_pc, 32'h20);
    check("pre_br_instr", o_instr_d, 32'h1C);

    // redirect + flush to 0x40
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    step();
    check("rdfl_pc", o_pc, 32'h40);
    check_ifid("rdfl", 32'h0, 32'h0, 32'h13, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rdfl2_pc", o_pc, 32'h44);
    check_ifid("rdfl2", 32'h40, 32'h44, 32'h40, 1'b1);

    // redirect + stall to 0x80: PC moves, IF/ID holds
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
    step();
    check("rdst_pc", o_pc, 32'h80);
    check_ifid("rdst", 32'h40, 32'h44, 32'h40, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rdst2_pc", o_pc, 32'h84);
    check_ifid("rdst2", 32'h80, 32'h84, 32'h80, 1'b1);

    // flush alone advances PC; flush with stall holds PC
    i_flush = 1'b1;
    step();
    check("fl_pc", o_pc, 32'h88);
    check_ifid("fl", 32'h0, 32'h0, 32'h13, 1'b0);
    i_stall = 1'b1;
    step();
    check("flst_pc", o_pc, 32'h88);
    check_ifid("flst", 32'h0, 32'h0, 32'h13, 1'b0);

    // imem address wraps at 13 bits while PC keeps counting
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h1FF8);
    step();
    check("wr_pc0", o_pc, 32'h1FF8);
    check("wr_addr0", {19'h0, o_imem_addr}, 32'h1FF8);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("wr_addr1", {19'h0, o_imem_addr}, 32'h1FFC);
    step();
    check("wr_addr2", {19'h0, o_imem_addr}, 32'h0);
    check("wr_pc2", o_pc, 32'h2000);
    check("wr_instr2", o_instr_d, 32'h1FFC);
    step();
    check_ifid("wr3", 32'h2000, 32'h2004, 32'h0, 1'b1);

    // 32-bit PC wrap
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    check("pcw_pc0", o_pc, 32'hFFFF_FFFC);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("pcw_pc1", o_pc, 32'h0);
    check("pcw_pc_d", o_pc_d, 32'hFFFF_FFFC);
    check("pcw_pc4_d", o_pc4_d, 32'h0);

    // reset overrides redirect, stall and flush
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    step();
    check("rstov_pc", o_pc, 32'h0);
    check_ifid("rstov", 32'h0, 32'h0, 32'h13, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("post_rst_pc", o_pc, 32'h4);
    check_ifid("post_rst", 32'h0, 32'h4, 32'h0, 1'b1);

    // misaligned redirect target
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h42);
    step();
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_pc", o_pc, 32'h40);
    check("mis_flag", {31'h0, o_misalign}, 32'h1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    check("mis_sticky", {31'h0, o_misalign}, 32'h1);
    check("mis_pc2", o_pc, 32'h48);
    i_reset = 1'b1;
    step();
    check("mis_clear", {31'h0, o_misalign}, 32'h0);
    i_reset = 1'b0;
`else
    check("mis_pc", o_pc, 32'h42);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("mis_pc2", o_pc, 32'h46);
    check("mis_pc_d", o_pc_d, 32'h42);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h0000_0000, giving the fetch address loaded on reset.
REQ-002 The block SHALL have a parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), giving the bubble encoding.
REQ-003 The block SHALL have the port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port i_reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have the port i_stall, input, 1 bit: hold PC and IF/ID register (load-use or structural stall).
REQ-006 The block SHALL have the port i_flush, input, 1 bit: replace IF/ID contents with a bubble.
REQ-007 The block SHALL have the port i_redirect, input, 1 bit: load PC from i_target (taken branch or jump).
REQ-008 The block SHALL have the port i_target, input, 32 bits: the redirect address.
REQ-009 The block SHALL have the port o_imem_addr, output, 13 bits: byte address to instruction memory, equal to PC[12:0].
REQ-010 The block SHALL have the port i_imem_rdata, input, 32 bits: combinational instruction word returned for o_imem_addr.
REQ-011 The block SHALL have the port o_pc, output, 32 bits: the current fetch PC.
REQ-012 The block SHALL have the IF/ID output ports o_pc_d (output, 32 bits), o_pc4_d (output, 32 bits), o_instr_d (output, 32 bits) and o_valid_d (output, 1 bit).

Function
REQ-013 The PC SHALL update on each edge with priority reset > i_redirect > i_stall > increment: RESET_PC, then i_target, then hold, then PC+4.
REQ-014 PC+4 SHALL be modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0; o_imem_addr SHALL wrap 13'h1FFC -> 13'h0000 because it truncates the PC.
REQ-015 The IF/ID register SHALL update on each edge with priority reset > i_flush > i_stall > capture.
- reset or flush: o_instr_d=NOP_INSTR, o_valid_d=0, o_pc_d=0, o_pc4_d=0.
- stall: hold all four.
- capture: o_pc_d=PC, o_pc4_d=PC+4, o_instr_d=i_imem_rdata, o_valid_d=1.
REQ-016 Fetch latency SHALL be exactly one cycle: the word at address PC appears on o_instr_d after the next edge.
REQ-017 i_redirect with i_stall asserted together SHALL load i_target into the PC while the IF/ID register holds, unless i_flush is also asserted.
REQ-018 i_redirect with i_flush asserted together SHALL load i_target into the PC and place a bubble in IF/ID; the target instruction SHALL be captured with valid=1 one edge later.
REQ-019 i_flush without i_redirect SHALL bubble IF/ID and SHALL advance the PC normally, or hold it if i_stall is asserted.
REQ-020 o_imem_addr and o_pc SHALL be driven combinationally from the PC register, with no path from i_imem_rdata to any output other than through the IF/ID register.

Reset
REQ-021 i_reset SHALL take effect at the next rising edge and override every other input, including reset asserted during a stall, flush or redirect.
REQ-022 After reset: o_pc=RESET_PC, o_imem_addr=RESET_PC[12:0], o_pc_d=0, o_pc4_d=0, o_instr_d=NOP_INSTR, o_valid_d=0, and o_misalign=0 when present.
REQ-023 The first edge after reset deassertion SHALL capture the word at RESET_PC with o_valid_d=1, unless i_stall or i_flush is asserted.

Configuration
REQ-024 With macro FETCH_MISALIGN_CHK_EN defined, the block SHALL add output port o_misalign (1 bit), which sets sticky on any accepted redirect with i_target[1:0]!=0 and clears only on reset; the PC SHALL load {i_target[31:2],2'b00} in that case.
REQ-025 Without FETCH_MISALIGN_CHK_EN, the port o_misalign SHALL be absent and the PC SHALL load i_target unmodified.

Verification
REQ-026 Reset then release with the memory returning word = addr: o_pc SHALL step 0,4,8,C and o_instr_d SHALL lag by one cycle, with o_valid_d=1 from the first post-reset edge.
REQ-027 i_stall held for 3 cycles at PC=0x10: o_pc SHALL stay 0x10 and o_instr_d, o_pc_d SHALL stay frozen, then resume at 0x14.
REQ-028 i_redirect=1, i_flush=1, i_target=0x40 at PC=0x20: the next cycle SHALL give o_pc=0x40, o_valid_d=0 and o_instr_d=0x00000013; the following cycle SHALL give o_pc_d=0x40 and o_valid_d=1.
REQ-029 i_redirect and i_stall asserted together with i_target=0x80: o_pc SHALL become 0x80 and IF/ID SHALL hold its prior contents.
REQ-030 Free-run from PC=0x1FF8: o_imem_addr SHALL go 0x1FF8, 0x1FFC, 0x0000 while o_pc SHALL go 0x2000.
REQ-031 i_reset asserted alongside i_redirect to 0x100: o_pc SHALL be RESET_PC; with FETCH_MISALIGN_CHK_EN, a redirect to 0x42 SHALL give o_pc=0x40 and o_misalign=1, held until reset.
